// File: rtl/db_cmd_pkg.sv
// db_cmd_pkg: opcodes, response codes, FSM state encodings and opcode decode helpers
// shared by the debug-link command decoder and the MCU debug adapter.
`default_nettype none

package db_cmd_pkg;

  localparam logic [7:0] OP_PAUSE    = 8'h01;
  localparam logic [7:0] OP_RESUME   = 8'h02;
  localparam logic [7:0] OP_RESET    = 8'h03;
  localparam logic [7:0] OP_MEM_RD_B = 8'h10;
  localparam logic [7:0] OP_MEM_RD_H = 8'h11;
  localparam logic [7:0] OP_MEM_RD_W = 8'h12;
  localparam logic [7:0] OP_MEM_WR_B = 8'h20;
  localparam logic [7:0] OP_MEM_WR_H = 8'h21;
  localparam logic [7:0] OP_MEM_WR_W = 8'h22;
  localparam logic [7:0] OP_REG_RD   = 8'h30;
  localparam logic [7:0] OP_REG_WR   = 8'h40;
  localparam logic [7:0] OP_STATUS   = 8'hF0;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  localparam logic [2:0] S_OPCODE = 3'd0;
  localparam logic [2:0] S_ARG    = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [3:0] {
    CMD_ILLEGAL = 4'd0,
    CMD_PAUSE   = 4'd1,
    CMD_RESUME  = 4'd2,
    CMD_RESET   = 4'd3,
    CMD_MEM_RD  = 4'd4,
    CMD_MEM_WR  = 4'd5,
    CMD_REG_RD  = 4'd6,
    CMD_REG_WR  = 4'd7,
    CMD_STATUS  = 4'd8
  } cmd_t;

  function automatic cmd_t decode_op(input logic [7:0] op);
    case (op)
      OP_PAUSE:                               return CMD_PAUSE;
      OP_RESUME:                              return CMD_RESUME;
      OP_RESET:                               return CMD_RESET;
      OP_MEM_RD_B, OP_MEM_RD_H, OP_MEM_RD_W:  return CMD_MEM_RD;
      OP_MEM_WR_B, OP_MEM_WR_H, OP_MEM_WR_W:  return CMD_MEM_WR;
      OP_REG_RD:                              return CMD_REG_RD;
      OP_REG_WR:                              return CMD_REG_WR;
      OP_STATUS:                              return CMD_STATUS;
      default:                                return CMD_ILLEGAL;
    endcase
  endfunction

  function automatic logic [3:0] cmd_argc(input cmd_t cmd);
    case (cmd)
      CMD_MEM_RD, CMD_REG_RD: return 4'd4;
      CMD_MEM_WR, CMD_REG_WR: return 4'd8;
      default:                return 4'd0;
    endcase
  endfunction

  function automatic logic cmd_is_access(input cmd_t cmd);
    return (cmd == CMD_MEM_RD) || (cmd == CMD_MEM_WR) ||
           (cmd == CMD_REG_RD) || (cmd == CMD_REG_WR);
  endfunction

  function automatic logic cmd_is_read(input cmd_t cmd);
    return (cmd == CMD_MEM_RD) || (cmd == CMD_REG_RD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/db_tx_serializer.sv
// db_tx_serializer: holds a 1- or 4-byte response and hands it to the UART transmitter
// MSB-first over the valid/ready handshake; o_done pulses as the last byte is accepted.
`default_nettype none

module db_tx_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_four,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_done
);

  logic [31:0] r_buf;
  logic [1:0]  r_cnt;
  logic        r_active;
  logic        w_accept;

  assign w_accept   = r_active && i_tx_ready;
  assign o_done     = w_accept && (r_cnt == 2'd0);
  assign o_tx_valid = r_active;
  assign o_tx_data  = r_active ? r_buf[31:24] : 8'h00;

  // Single-byte responses arrive left-justified, so the output byte is always r_buf[31:24].
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf    <= 32'h0;
      r_cnt    <= 2'd0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_buf    <= i_data;
      r_cnt    <= i_four ? 2'd3 : 2'd0;
      r_active <= 1'b1;
    end else if (w_accept) begin
      if (r_cnt == 2'd0) begin
        r_active <= 1'b0;
      end else begin
        r_buf <= {r_buf[23:0], 8'h00};
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/db_cmd_decoder.sv
// db_cmd_decoder: assembles debug-link packets from the UART rx stream, issues one-shot
// commands to the MCU debug adapter and returns ack/read data. Option: DB_RX_TIMEOUT_EN.
`default_nettype none

module db_cmd_decoder
  import db_cmd_pkg::*;
#(
  parameter int CLK_RATE   = 50,
  parameter int TIMEOUT_US = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic        i_mcu_busy,
  input  logic        i_error,
  input  logic [31:0] i_d_rd,
  output logic        o_valid,
  output logic        o_pause,
  output logic        o_resume,
  output logic        o_mcu_reset,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic        o_reg_rd,
  output logic        o_reg_wr,
  output logic [1:0]  o_mem_size,
  output logic [31:0] o_addr,
  output logic [31:0] o_d_in
);

  localparam int TIMEOUT_CYC = CLK_RATE * TIMEOUT_US;

  logic [2:0]  r_state;
  cmd_t        r_cmd;
  mem_size_t   r_size;
  logic [3:0]  r_argc;
  logic [63:0] r_args;
  logic        r_paused;
  logic        r_overrun;
  logic [31:0] r_addr;
  logic [31:0] r_d_in;
  mem_size_t   r_mem_size;

  logic [2:0]  w_next_state;
  cmd_t        w_cmd_dec;
  logic [63:0] w_next_args;
  logic        w_issue;
  logic        w_ld;
  logic [31:0] w_ld_data;
  logic        w_ld_four;
  logic        w_ser_done;
  logic        w_timeout;
  logic        w_busy_state;

  assign w_cmd_dec    = decode_op(i_rx_data);
  assign w_next_args  = {r_args[55:0], i_rx_data};
  assign w_busy_state = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_RESP);

`ifdef DB_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tmo;

  always_ff @(posedge clk) begin
    if (reset || (r_state != S_ARG) || i_rx_valid) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_timeout = (r_tmo == TW'(TIMEOUT_CYC - 1)) && !i_rx_valid;
`else
  // Parameters only shape the optional timeout counter.
  assign w_timeout = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_ld         = 1'b0;
    w_ld_data    = 32'h0;
    w_ld_four    = 1'b0;
    case (r_state)
      S_OPCODE: begin
        if (i_rx_valid) begin
          if (w_cmd_dec == CMD_ILLEGAL) begin
            w_ld         = 1'b1;
            w_ld_data    = {NAK, 24'h0};
            w_next_state = S_RESP;
          end else if (cmd_argc(w_cmd_dec) == 4'd0) begin
            w_next_state = S_ISSUE;
          end else begin
            w_next_state = S_ARG;
          end
        end
      end
      S_ARG: begin
        if (i_rx_valid) begin
          if (r_argc == 4'd1) w_next_state = S_ISSUE;
        end else if (w_timeout) begin
          w_next_state = S_OPCODE;
        end
      end
      S_ISSUE: begin
        case (r_cmd)
          CMD_MEM_RD, CMD_MEM_WR, CMD_REG_RD, CMD_REG_WR: w_issue = r_paused;
          CMD_PAUSE:  w_issue = !r_paused;
          CMD_RESUME: w_issue = r_paused;
          CMD_RESET:  w_issue = 1'b1;
          default:    w_issue = 1'b0;
        endcase
        if (w_issue) begin
          w_next_state = S_WAIT;
        end else begin
          w_ld         = 1'b1;
          w_next_state = S_RESP;
          if (r_cmd == CMD_STATUS)
            w_ld_data = {6'b0, r_overrun, r_paused, 24'h0};
          else if ((r_cmd == CMD_PAUSE) || (r_cmd == CMD_RESUME))
            w_ld_data = {ACK, 24'h0};
          else
            w_ld_data = {NAK, 24'h0};
        end
      end
      S_WAIT: begin
        if (!i_mcu_busy) begin
          w_ld         = 1'b1;
          w_next_state = S_RESP;
          if (i_error) begin
            w_ld_data = {NAK, 24'h0};
          end else if (cmd_is_read(r_cmd)) begin
            w_ld_data = i_d_rd;
            w_ld_four = 1'b1;
          end else begin
            w_ld_data = {ACK, 24'h0};
          end
        end
      end
      S_RESP: begin
        if (w_ser_done) w_next_state = S_OPCODE;
      end
      default: w_next_state = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_OPCODE;
      r_cmd      <= CMD_ILLEGAL;
      r_size     <= MEM_BYTE;
      r_argc     <= 4'd0;
      r_args     <= 64'h0;
      r_paused   <= 1'b0;
      r_overrun  <= 1'b0;
      r_addr     <= 32'h0;
      r_d_in     <= 32'h0;
      r_mem_size <= MEM_BYTE;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_OPCODE: begin
          if (i_rx_valid) begin
            r_cmd  <= w_cmd_dec;
            r_size <= mem_size_t'(i_rx_data[1:0]);
            r_argc <= cmd_argc(w_cmd_dec);
          end
        end
        S_ARG: begin
          if (i_rx_valid) begin
            r_args <= w_next_args;
            r_argc <= r_argc - 4'd1;
            // Adapter-facing fields change only for an access that will actually issue.
            if ((r_argc == 4'd1) && cmd_is_access(r_cmd) && r_paused) begin
              if (cmd_argc(r_cmd) == 4'd8) begin
                r_addr <= w_next_args[63:32];
                r_d_in <= w_next_args[31:0];
              end else begin
                r_addr <= w_next_args[31:0];
                r_d_in <= 32'h0;
              end
              r_mem_size <= ((r_cmd == CMD_MEM_RD) || (r_cmd == CMD_MEM_WR)) ? r_size : MEM_BYTE;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue && (r_cmd == CMD_PAUSE)) r_paused <= 1'b1;
          if (w_issue && ((r_cmd == CMD_RESUME) || (r_cmd == CMD_RESET))) r_paused <= 1'b0;
          if (r_cmd == CMD_STATUS) r_overrun <= 1'b0;
        end
        default: ;
      endcase
      // A byte dropped in the same cycle a status read clears the flag still counts.
      if (i_rx_valid && w_busy_state) r_overrun <= 1'b1;
    end
  end

  assign o_valid     = w_issue;
  assign o_pause     = w_issue && (r_cmd == CMD_PAUSE);
  assign o_resume    = w_issue && (r_cmd == CMD_RESUME);
  assign o_mcu_reset = w_issue && (r_cmd == CMD_RESET);
  assign o_mem_rd    = w_issue && (r_cmd == CMD_MEM_RD);
  assign o_mem_wr    = w_issue && (r_cmd == CMD_MEM_WR);
  assign o_reg_rd    = w_issue && (r_cmd == CMD_REG_RD);
  assign o_reg_wr    = w_issue && (r_cmd == CMD_REG_WR);
  assign o_mem_size  = r_mem_size;
  assign o_addr      = r_addr;
  assign o_d_in      = r_d_in;

  db_tx_serializer u_ser (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_ld),
    .i_data     (w_ld_data),
    .i_four     (w_ld_four),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done     (w_ser_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_db_cmd_decoder.sv
// tb_db_cmd_decoder: directed self-checking bench for db_cmd_decoder.
`default_nettype none

module tb_db_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        mcu_busy = 1'b0;
  logic        error = 1'b0;
  logic [31:0] d_rd = 32'h0;
  logic        valid, pause, resume, mcu_reset, mem_rd, mem_wr, reg_rd, reg_wr;
  logic [1:0]  mem_size;
  logic [31:0] addr, d_in;
  logic [6:0]  strobes;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  logic [7:0] tx_q[$];

  assign strobes = {pause, resume, mcu_reset, mem_rd, mem_wr, reg_rd, reg_wr};

  always #5 clk = ~clk;

  db_cmd_decoder #(.CLK_RATE(1), .TIMEOUT_US(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .i_mcu_busy  (mcu_busy),
    .i_error     (error),
    .i_d_rd      (d_rd),
    .o_valid     (valid),
    .o_pause     (pause),
    .o_resume    (resume),
    .o_mcu_reset (mcu_reset),
    .o_mem_rd    (mem_rd),
    .o_mem_wr    (mem_wr),
    .o_reg_rd    (reg_rd),
    .o_reg_wr    (reg_wr),
    .o_mem_size  (mem_size),
    .o_addr      (addr),
    .o_d_in      (d_in)
  );

  always @(negedge clk) begin
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (valid) n_valid <= n_valid + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(input logic [7:0] b);
    tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 60 && tx_q.size() < n; i++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({valid, strobes, tx_valid} !== 9'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 0", {valid, strobes, tx_valid});
    end
    checks++;
    if ({tx_data, mem_size, addr, d_in} !== 74'b0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h/%h want 0", tx_data, mem_size, addr, d_in);
    end
  endtask

  task automatic test_nak_unpaused();
    int v0;
    logic [7:0] got;
    tx_q.delete();
    v0 = n_valid;
    rx(8'h10); rx(8'h00); rx(8'h00); rx(8'h00); rx(8'h04);
    wait_tx(1);
    got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    checks++;
    if (tx_q.size() != 1 || got !== 8'hEE) begin
      errors++; $display("FAIL nak_unpaused got n=%0d b=%h want n=1 b=ee", tx_q.size(), got);
    end
    checks++;
    if (n_valid != v0) begin
      errors++; $display("FAIL nak_no_valid got %0d pulses want 0", n_valid - v0);
    end
  endtask

  task automatic test_pause();
    int v0;
    logic [7:0] got;
    tx_q.delete();
    v0 = n_valid;
    rx(8'h01);
    checks++;
    if (valid !== 1'b1 || strobes !== 7'b1000000) begin
      errors++; $display("FAIL pause_issue got v=%b s=%b want v=1 s=1000000", valid, strobes);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL pause_oneshot got %b want 0", valid);
    end
    wait_tx(1);
    got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    checks++;
    if (tx_q.size() != 1 || got !== 8'hA5 || n_valid != v0 + 1) begin
      errors++; $display("FAIL pause_ack got n=%0d b=%h pulses=%0d want 1/a5/1", tx_q.size(), got, n_valid - v0);
    end
    tx_q.delete();
    v0 = n_valid;
    rx(8'h01);
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL pause_again_valid got %b want 0", valid);
    end
    wait_tx(1);
    got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    checks++;
    if (tx_q.size() != 1 || got !== 8'hA5 || n_valid != v0) begin
      errors++; $display("FAIL pause_again_ack got n=%0d b=%h pulses=%0d want 1/a5/0", tx_q.size(), got, n_valid - v0);
    end
  endtask

  task automatic test_mem_rd();
    logic [7:0] exp [4];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    tx_q.delete();
    d_rd = 32'hDEADBEEF;
    rx(8'h12); rx(8'h00); rx(8'h00); rx(8'h00);
    mcu_busy = 1'b1;
    rx(8'h08);
    checks++;
    if (valid !== 1'b1 || strobes !== 7'b0001000 || mem_size !== 2'd2 || addr !== 32'h8) begin
      errors++; $display("FAIL memrd_issue got v=%b s=%b sz=%0d a=%h want 1/0001000/2/8", valid, strobes, mem_size, addr);
    end
    repeat (2) tick();
    checks++;
    if (tx_valid !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL memrd_busy_wait got txv=%b v=%b want 0/0", tx_valid, valid);
    end
    mcu_busy = 1'b0;
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hDE) begin
      errors++; $display("FAIL memrd_latency got txv=%b d=%h want 1/de", tx_valid, tx_data);
    end
    for (int k = 0; k < 12; k++) begin
      tx_ready = !(k >= 2 && k < 7);
      if (k >= 2 && k < 7) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hBE) begin
          errors++; $display("FAIL memrd_stall_hold k=%0d got v=%b d=%h want 1/be", k, tx_valid, tx_data);
        end
      end
      tick();
    end
    tx_ready = 1'b1;
    checks++;
    if (tx_q.size() != 4) begin
      errors++; $display("FAIL memrd_count got %0d want 4", tx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tx_q[i] !== exp[i]) begin
          errors++; $display("FAIL memrd_byte%0d got %h want %h", i, tx_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reg_wr();
    int v0;
    logic [7:0] got;
    for (int e = 0; e < 2; e++) begin
      tx_q.delete();
      v0 = n_valid;
      rx(8'h40); rx(8'h00); rx(8'h00); rx(8'h00); rx(8'h05);
      rx(8'h12); rx(8'h34); rx(8'h56);
      mcu_busy = 1'b1;
      rx(8'h78);
      checks++;
      if (valid !== 1'b1 || strobes !== 7'b0000001 || addr !== 32'h5 || d_in !== 32'h12345678) begin
        errors++; $display("FAIL regwr_issue e=%0d got v=%b s=%b a=%h d=%h", e, valid, strobes, addr, d_in);
      end
      tick();
      mcu_busy = 1'b0;
      error = (e == 1);
      wait_tx(1);
      error = 1'b0;
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      checks++;
      if (tx_q.size() != 1 || got !== ((e == 1) ? 8'hEE : 8'hA5) || n_valid != v0 + 1) begin
        errors++; $display("FAIL regwr_resp e=%0d got n=%0d b=%h pulses=%0d", e, tx_q.size(), got, n_valid - v0);
      end
    end
  endtask

  task automatic test_overrun_status();
    logic [7:0] got;
    tx_q.delete();
    d_rd = 32'h000000C3;
    rx(8'h30); rx(8'h00); rx(8'h00); rx(8'h00);
    mcu_busy = 1'b1;
    rx(8'h01);
    rx(8'h55);
    mcu_busy = 1'b0;
    wait_tx(4);
    checks++;
    if (tx_q.size() != 4 || tx_q[0] !== 8'h00 || tx_q[1] !== 8'h00 ||
        tx_q[2] !== 8'h00 || tx_q[3] !== 8'hC3) begin
      errors++; $display("FAIL regrd_resp got n=%0d want 00 00 00 c3", tx_q.size());
    end
    for (int s = 0; s < 2; s++) begin
      tx_q.delete();
      rx(8'hF0);
      wait_tx(1);
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      checks++;
      if (tx_q.size() != 1 || got !== ((s == 0) ? 8'h03 : 8'h01)) begin
        errors++; $display("FAIL status%0d got n=%0d b=%h want %h", s, tx_q.size(), got, (s == 0) ? 8'h03 : 8'h01);
      end
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    logic [7:0] got;
    rx(8'h10); rx(8'h00); rx(8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({valid, strobes, tx_valid, tx_data, mem_size, addr, d_in} !== 83'b0) begin
      errors++; $display("FAIL midreset_outputs got v=%b s=%b a=%h d=%h", valid, strobes, addr, d_in);
    end
    tx_q.delete();
    v0 = n_valid;
    rx(8'h01);
    checks++;
    if (valid !== 1'b1 || strobes !== 7'b1000000) begin
      errors++; $display("FAIL midreset_fresh got v=%b s=%b want 1/1000000", valid, strobes);
    end
    wait_tx(1);
    got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    checks++;
    if (tx_q.size() != 1 || got !== 8'hA5 || n_valid != v0 + 1) begin
      errors++; $display("FAIL midreset_ack got n=%0d b=%h want 1/a5", tx_q.size(), got);
    end
  endtask

`ifdef DB_RX_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] got;
    tx_q.delete();
    rx(8'h30); rx(8'h00);
    repeat (40) tick();
    checks++;
    if (tx_q.size() != 0) begin
      errors++; $display("FAIL timeout_silent got %0d bytes want 0", tx_q.size());
    end
    rx(8'h01);
    wait_tx(1);
    got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    checks++;
    if (tx_q.size() != 1 || got !== 8'hA5) begin
      errors++; $display("FAIL timeout_fresh got n=%0d b=%h want 1/a5", tx_q.size(), got);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nak_unpaused();
    test_pause();
    test_mem_rd();
    test_reg_wr();
    test_overrun_status();
    test_reset_mid();
`ifdef DB_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
